sram_ctrl: RTL and testbench

Access sequencer for the mixed-signal SRAM macro. It accepts one read or write request at a time over a valid/ready handshake. It drives the precharge, wordline-select, write-driver and sense-enable controls in a fixed, parameterised cycle sequence. It then digitises the real-valued sense-amplifier outputs into a registered read response. It sits between the digital host port and the analog array/sense-amp path.

---
 rtl/sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - access sequencer for the mixed-signal SRAM macro
// Drives precharge/wordline/write/sense controls in a fixed cycle sequence and digitises sense-amp outputs.
module sram_ctrl #(
   parameter int ROWS  = 16,
   parameter int COLS  = 8,
   parameter int T_PRE = 2,
   parameter int T_WL  = 3,
   parameter int T_WR  = 2,
   parameter int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [COLS-1:0] req_wdata,
   output logic            rsp_valid,
   output logic            rsp_err,
   output logic [COLS-1:0] rsp_rdata,
   output logic            pre_en,
   output logic [ROWS-1:0] row_en,
   output logic            wr_en,
   output logic [COLS-1:0] wr_data,
   output logic            sa_en,
   input  real             preout [0:COLS-1]
);

   localparam int T_MAX = (T_PRE > T_WL) ? ((T_PRE > T_WR) ? T_PRE : T_WR)
                                         : ((T_WL > T_WR) ? T_WL : T_WR);
   localparam int CW    = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, WRITE, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [COLS-1:0] wdata_q;

   function automatic logic [ROWS-1:0] row_sel(input logic [AW-1:0] a);
      return ROWS'(1) << a;
   endfunction

   // Every output is a flop, set on the edge that enters the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         pre_en    <= 1'b0;
         row_en    <= '0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         sa_en     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (32'(req_addr) >= ROWS) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state  <= PRE;
                     pre_en <= 1'b1;
                     cnt    <= CW'(T_PRE - 1);
                  end
               end
            end
            PRE: begin
               if (cnt == '0) begin
                  pre_en <= 1'b0;
                  row_en <= row_sel(addr_q);
                  if (we_q) begin
                     state   <= WRITE;
                     wr_en   <= 1'b1;
                     wr_data <= wdata_q;
                     cnt     <= CW'(T_WR - 1);
                  end else begin
                     state <= WL;
                     cnt   <= CW'(T_WL - 1);
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WL: begin
               if (cnt == '0) begin
                  state <= SENSE;
                  sa_en <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SENSE: begin
               // Exactly 0.8 V resolves to 1.
               for (int c = 0; c < COLS; c++) begin
                  rsp_rdata[c] <= (preout[c] >= 0.8);
               end
               state     <= DONE;
               sa_en     <= 1'b0;
               row_en    <= '0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
            end
            WRITE: begin
               if (cnt == '0) begin
                  state     <= DONE;
                  row_en    <= '0;
                  wr_en     <= 1'b0;
                  wr_data   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl
// Vector table, hand sequences and random traffic against a row-memory model.
module tb_sram_ctrl;
   localparam int ROWS = 16, COLS = 8, TP = 2, TW = 3, TR = 2, AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            req_valid, req_we, req_ready;
   logic [AW-1:0]   req_addr;
   logic [COLS-1:0] req_wdata;
   logic            rsp_valid, rsp_err;
   logic [COLS-1:0] rsp_rdata;
   logic            pre_en, wr_en, sa_en;
   logic [ROWS-1:0] row_en;
   logic [COLS-1:0] wr_data;
   real             pv [0:COLS-1];

   logic            req_valid_b, req_we_b, req_ready_b;
   logic [3:0]      req_addr_b;
   logic [COLS-1:0] req_wdata_b;
   logic            rsp_valid_b, rsp_err_b;
   logic [COLS-1:0] rsp_rdata_b;
   logic            pre_en_b, wr_en_b, sa_en_b;
   logic [11:0]     row_en_b;
   logic [COLS-1:0] wr_data_b;

   sram_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .pre_en(pre_en), .row_en(row_en), .wr_en(wr_en), .wr_data(wr_data),
      .sa_en(sa_en), .preout(pv)
   );

   sram_ctrl #(.ROWS(12)) dut12 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
      .pre_en(pre_en_b), .row_en(row_en_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
      .sa_en(sa_en_b), .preout(pv)
   );

   int checks = 0;
   int errors = 0;
   bit row_b_seen = 1'b0;
   logic [7:0] mem [ROWS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] all_out();
      return {req_ready, rsp_valid, rsp_err, rsp_rdata, pre_en, row_en, wr_en, wr_data, sa_en};
   endfunction

   function automatic logic [27:0] act_ctrl();
      return {rsp_valid, pre_en, row_en, wr_en, wr_data, sa_en};
   endfunction

   function automatic int rsp_cycle(input bit we);
      return we ? TP + TR + 1 : TP + TW + 2;
   endfunction

   // Expected array controls in cycle k after acceptance, straight from the timing rules.
   function automatic logic [27:0] exp_ctrl(input int k, input bit we, input int addr, input logic [7:0] wd);
      logic pre, wr, sa, rv, act;
      logic [15:0] row;
      logic [7:0] wdo;
      pre = (k >= 1) && (k <= TP);
      if (we) begin
         act = (k > TP) && (k <= TP + TR);
         wr  = act;
         wdo = act ? wd : 8'h00;
         sa  = 1'b0;
      end else begin
         act = (k > TP) && (k <= TP + TW + 1);
         wr  = 1'b0;
         wdo = 8'h00;
         sa  = (k == TP + TW + 1);
      end
      row = act ? (16'd1 << addr) : 16'd0;
      rv  = (k == rsp_cycle(we));
      return {rv, pre, row, wr, wdo, sa};
   endfunction

   always @(negedge clk) begin
      check("inv_pre_row", pre_en & (|row_en), 0);
      check("inv_wr_sa", wr_en & sa_en, 0);
      check("inv_onehot", $onehot0(row_en), 1);
      if (|row_en_b) row_b_seen = 1'b1;
   end

   // Called on a negedge; returns on the rsp cycle negedge (hold) or one cycle later.
   task automatic run_req(input bit we, input logic [3:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input bit hold, input string tag);
      int n, rc;
      rc = rsp_cycle(we);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, n < 40, 1);
      for (int k = 1; k <= rc; k++) begin
         @(negedge clk);
         if (hold) {req_we, req_addr, req_wdata} = 13'($urandom);
         else req_valid = 1'b0;
         check($sformatf("%s_ctrl_c%0d", tag, k), act_ctrl(), exp_ctrl(k, we, int'(addr), wd));
      end
      check({tag, "_err"}, rsp_err, 0);
      check({tag, "_rdata"}, rsp_rdata, exp_rd);
      if (!hold) begin
         @(negedge clk);
         check({tag, "_ready_after"}, {req_ready, rsp_valid}, 2'b10);
      end
   endtask

   typedef struct {
      bit         we;
      logic [3:0] addr;
      logic [7:0] wd;
      logic [7:0] hi;
      real        lhi;
      real        llo;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [8];

   task automatic set_pv_from(input logic [7:0] bits);
      for (int c = 0; c < COLS; c++)
         pv[c] = bits[c] ? 0.8 + real'($urandom_range(70)) / 100.0 : real'($urandom_range(79)) / 100.0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'd5,  8'hA5, 8'h00, 0.0, 0.0,  8'h00};
      tbl[1] = '{1'b0, 4'd5,  8'h00, 8'hA5, 1.5, 0.0,  8'hA5};
      tbl[2] = '{1'b0, 4'd3,  8'h00, 8'hFF, 0.8, 0.0,  8'hFF};
      tbl[3] = '{1'b0, 4'd3,  8'h00, 8'h00, 1.5, 0.79, 8'h00};
      tbl[4] = '{1'b1, 4'd15, 8'h3C, 8'h00, 0.0, 0.0,  8'h00};
      tbl[5] = '{1'b0, 4'd15, 8'h00, 8'h3C, 1.5, 0.0,  8'h3C};
      tbl[6] = '{1'b1, 4'd0,  8'h00, 8'h00, 0.0, 0.0,  8'h00};
      tbl[7] = '{1'b0, 4'd0,  8'hFF, 8'h5A, 1.2, 0.3,  8'h5A};
      for (int r = 0; r < ROWS; r++) mem[r] = 8'h00;

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
      for (int c = 0; c < COLS; c++) pv[c] = 0.0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_out_%0d", i), all_out(), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", {req_ready, req_ready_b}, 2'b11);

      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < COLS; c++) pv[c] = tbl[i].hi[c] ? tbl[i].lhi : tbl[i].llo;
         run_req(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
      end

      for (int c = 0; c < COLS; c++) pv[c] = 0.0;
      pv[0] = 0.8;
      pv[1] = 0.79;
      run_req(1'b0, 4'd2, 8'h00, 8'h01, 1'b0, "threshold");

      for (int i = 0; i < 6; i++) begin
         logic [3:0] a;
         logic [7:0] d;
         a = 4'($urandom);
         d = 8'($urandom);
         if (i % 2 == 0) begin
            mem[a] = d;
            run_req(1'b1, a, d, 8'h00, 1'b1, $sformatf("b2b%0d", i));
         end else begin
            set_pv_from(mem[a]);
            run_req(1'b0, a, d, mem[a], 1'b1, $sformatf("b2b%0d", i));
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b_idle", {req_ready, rsp_valid}, 2'b10);
      @(negedge clk);
      check("b2b_no_extra", {req_ready, rsp_valid}, 2'b10);

      // Reset in the middle of a read: controls drop at once, no response.
      set_pv_from(8'hFF);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (TP + 1) @(negedge clk);
      check("midrst_in_wl", row_en, 16'h0080);
      #1 rst_n = 1'b0;
      #1 check("midrst_drop", all_out(), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("midrst_norsp_%0d", i), rsp_valid, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("midrst_after_%0d", i), {req_ready, rsp_valid}, 2'b10);
      end
      set_pv_from(8'h96);
      run_req(1'b0, 4'd7, 8'h00, 8'h96, 1'b0, "midrst_fresh");

      req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 4'd13;
      check("r12_ready", req_ready_b, 1);
      @(negedge clk);
      req_valid_b = 1'b0;
      check("r12_rsp", {rsp_valid_b, rsp_err_b, rsp_rdata_b}, {2'b11, 8'h00});
      @(negedge clk);
      check("r12_ready_c2", {req_ready_b, rsp_valid_b, rsp_err_b}, 3'b101);
      check("r12_no_row", row_b_seen, 0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] a;
         logic [7:0] d;
         a = 4'($urandom);
         d = 8'($urandom);
         if ($urandom_range(1) == 1) begin
            mem[a] = d;
            run_req(1'b1, a, d, 8'h00, 1'b0, $sformatf("rnd%0d", i));
         end else begin
            set_pv_from(mem[a]);
            run_req(1'b0, a, d, mem[a], 1'b0, $sformatf("rnd%0d", i));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
